// File: rtl/eth_loopback_pkg.sv
// Shared types and constants for the Ethernet frame loopback.
package eth_loopback_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } tx_state_t;

  localparam int MAC_ADDR_BYTES = 6;
  localparam int ETH_HDR_BYTES  = 14;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } mem_word_t;

endpackage

// File: rtl/eth_loopback_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module eth_loopback_ram #(
  parameter  int DEPTH = 2048,
  parameter  int WIDTH = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/eth_frame_loopback.sv
// Store-and-forward Ethernet loopback: frames commit on a clean tlast, optional MAC swap on TX.
// Define ETH_LOOPBACK_STATS_EN to add forwarded/dropped frame and forwarded byte counters.
module eth_frame_loopback
  import eth_loopback_pkg::*;
#(
  parameter int DEPTH           = 2048,
  parameter int MAX_FRAME_LEN   = 1518,
  parameter int MIN_FRAME_LEN   = 14,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_axis_tdata_i,
  input  logic                       rx_axis_tvalid_i,
  output logic                       rx_axis_tready_o,
  input  logic                       rx_axis_tlast_i,
  input  logic                       rx_axis_tuser_i,
  output logic [7:0]                 tx_axis_tdata_o,
  output logic                       tx_axis_tvalid_o,
  input  logic                       tx_axis_tready_i,
  output logic                       tx_axis_tlast_o,
  output logic                       tx_axis_tuser_o,
  input  logic                       cfg_swap_mac,
  output logic                       frame_dropped,
  output logic                       fifo_overflow,
`ifdef ETH_LOOPBACK_STATS_EN
  output logic [31:0]                stat_frames_fwd,
  output logic [31:0]                stat_frames_drop,
  output logic [31:0]                stat_bytes_fwd,
`endif
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]              DEPTH_P  = PW'(DEPTH);
  localparam logic [11:0]                LEN_MIN  = 12'(MIN_FRAME_LEN);
  localparam logic [11:0]                LEN_MAX  = 12'(MAX_FRAME_LEN);
  localparam logic [11:0]                LEN_SAT  = 12'(MAX_FRAME_LEN + 1);
  localparam logic [11:0]                MAC_B    = 12'(MAC_ADDR_BYTES);
  localparam logic [11:0]                SWAP_END = 12'(2 * MAC_ADDR_BYTES);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_MAX  = '1;

  // RX state
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [11:0]   len_q, len_d, len_inc;
  logic          ovf_q, ovf_d, rdy_q;
  logic          drop_q, drop_d, ovfp_q, ovfp_d, commit_q, commit_d;
  logic          rx_beat, full, wr_en, frame_ok;

  // TX state
  tx_state_t     state_q, state_d;
  logic [11:0]   idx_q, idx_d, off;
  logic          swap_q, swap_d, swap_sel, done_q, done_d;
  logic [PW-1:0] rd_base_q, nxt_base_q, nxt_base_d, end_base, rd_addr_full;
  logic          rvld_q, issue, rd_last, pop, pop_f, push, final_hs, out_vld;
  logic [1:0]    cnt_q, cnt_d;
  logic [2:0]    occ;
  mem_word_t     slot0_q, slot0_d, slot1_q, slot1_d, ram_rdata, out_word, wr_word;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

  assign rx_axis_tready_o = rdy_q;
  assign frame_dropped    = drop_q;
  assign fifo_overflow    = ovfp_q;
  assign frame_count      = frame_cnt_q;

  assign rx_beat  = rx_axis_tvalid_i & rdy_q;
  assign full     = (wr_ptr_q - rd_base_q) == DEPTH_P;
  assign wr_en    = rx_beat & ~full & ~ovf_q;
  assign len_inc  = (len_q == LEN_SAT) ? len_q : len_q + 12'd1;
  assign frame_ok = ~rx_axis_tuser_i & (len_inc >= LEN_MIN) & (len_inc <= LEN_MAX)
                  & ~ovf_q & ~full & (frame_cnt_q != CNT_MAX);
  assign wr_word  = '{last: rx_axis_tlast_i, data: rx_axis_tdata_i};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    drop_d       = 1'b0;
    ovfp_d       = 1'b0;
    commit_d     = 1'b0;
    if (rx_beat) begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      ovfp_d = full & ~ovf_q;
      ovf_d  = ovf_q | full;
      len_d  = len_inc;
      if (rx_axis_tlast_i) begin
        len_d = '0;
        ovf_d = 1'b0;
        if (frame_ok) begin
          commit_ptr_d = wr_ptr_q + 1'b1;
          commit_d     = 1'b1;
        end else begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q        <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      ovfp_q       <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      rdy_q        <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      ovfp_q       <= ovfp_d;
      commit_q     <= commit_d;
    end
  end

  eth_loopback_ram #(.DEPTH(DEPTH), .WIDTH($bits(mem_word_t))) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_word),
    .re_i    (issue),
    .raddr_i (rd_addr_full[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Fresh RAM data bypasses the skid so a frame can start the cycle it is read.
  assign out_vld  = (cnt_q != 2'd0) | rvld_q;
  assign out_word = (cnt_q != 2'd0) ? slot0_q : ram_rdata;
  assign pop      = out_vld & tx_axis_tready_i;
  assign final_hs = pop & out_word.last;
  assign rd_last  = rvld_q & ram_rdata.last;
  assign occ      = {1'b0, cnt_q} + {2'b0, rvld_q} - {2'b0, pop};
  assign end_base = rd_last ? rd_base_q + PW'(idx_q) : nxt_base_q;

  assign tx_axis_tvalid_o = out_vld;
  assign tx_axis_tdata_o  = out_vld ? out_word.data : 8'd0;
  assign tx_axis_tlast_o  = out_vld & out_word.last;
  assign tx_axis_tuser_o  = 1'b0;

  always_comb begin
    swap_sel = (state_q == LOAD) ? cfg_swap_mac : swap_q;
    off      = idx_q;
    if (swap_sel && idx_q < MAC_B)         off = idx_q + MAC_B;
    else if (swap_sel && idx_q < SWAP_END) off = idx_q - MAC_B;
    rd_addr_full = rd_base_q + PW'(off);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    swap_d     = swap_q;
    done_d     = done_q;
    nxt_base_d = nxt_base_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d  = '0;
        done_d = 1'b0;
        if (frame_cnt_q != '0) state_d = LOAD;
      end
      LOAD: begin
        swap_d  = cfg_swap_mac;
        issue   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        // Stop fetching once the last flag comes back so nothing past the frame is read.
        issue = ~done_q & ~rd_last & (occ <= 3'd1);
        if (rd_last) begin
          done_d     = 1'b1;
          nxt_base_d = end_base;
        end
        if (final_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) idx_d = idx_q + 12'd1;
  end

  always_comb begin
    push    = rvld_q & ~((cnt_q == 2'd0) & pop);
    pop_f   = pop & (cnt_q != 2'd0);
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop_f};
    if (pop_f) begin
      slot0_d = slot1_q;
      if (push && cnt_q == 2'd1) slot0_d = ram_rdata;
      if (push && cnt_q == 2'd2) slot1_d = ram_rdata;
    end else if (push) begin
      if (cnt_q == 2'd0) slot0_d = ram_rdata;
      else               slot1_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      swap_q      <= 1'b0;
      done_q      <= 1'b0;
      nxt_base_q  <= '0;
      rd_base_q   <= '0;
      rvld_q      <= 1'b0;
      cnt_q       <= '0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      swap_q     <= swap_d;
      done_q     <= done_d;
      nxt_base_q <= nxt_base_d;
      rvld_q     <= issue;
      cnt_q      <= cnt_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      if (final_hs) rd_base_q <= end_base;
      case ({commit_q, final_hs})
        2'b10:   frame_cnt_q <= frame_cnt_q + 1'b1;
        2'b01:   frame_cnt_q <= frame_cnt_q - 1'b1;
        default: frame_cnt_q <= frame_cnt_q;
      endcase
    end
  end

`ifdef ETH_LOOPBACK_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_frames_fwd  <= '0;
      stat_frames_drop <= '0;
      stat_bytes_fwd   <= '0;
    end else begin
      if (final_hs) stat_frames_fwd  <= stat_frames_fwd + 32'd1;
      if (drop_q)   stat_frames_drop <= stat_frames_drop + 32'd1;
      if (pop)      stat_bytes_fwd   <= stat_bytes_fwd + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_frame_loopback.sv
// Randomized scoreboard bench for eth_frame_loopback.
module tb_eth_frame_loopback;

  localparam int DEPTH = 2048;
  localparam int MAXL  = 1518;
  localparam int MINL  = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_tdata = '0;
  logic       rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0, rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid, tx_tlast, tx_tuser;
  logic       tx_tready = 1'b0;
  logic       cfg_swap = 1'b0;
  logic       frame_dropped, fifo_overflow;
  logic [7:0] frame_count;
`ifdef ETH_LOOPBACK_STATS_EN
  logic [31:0] st_fwd, st_drop, st_bytes;
`endif

  eth_frame_loopback dut (
    .clk              (clk),
    .reset            (reset),
    .rx_axis_tdata_i  (rx_tdata),
    .rx_axis_tvalid_i (rx_tvalid),
    .rx_axis_tready_o (rx_tready),
    .rx_axis_tlast_i  (rx_tlast),
    .rx_axis_tuser_i  (rx_tuser),
    .tx_axis_tdata_o  (tx_tdata),
    .tx_axis_tvalid_o (tx_tvalid),
    .tx_axis_tready_i (tx_tready),
    .tx_axis_tlast_o  (tx_tlast),
    .tx_axis_tuser_o  (tx_tuser),
    .cfg_swap_mac     (cfg_swap),
    .frame_dropped    (frame_dropped),
    .fifo_overflow    (fifo_overflow),
`ifdef ETH_LOOPBACK_STATS_EN
    .stat_frames_fwd  (st_fwd),
    .stat_frames_drop (st_drop),
    .stat_bytes_fwd   (st_bytes),
`endif
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, t_last = 0, first_tv_cyc = -1;
  int outstanding = 0, out_bytes = 0, drop_cnt = 0, ovf_cnt = 0;
  logic [8:0] exp_q[$];
  int         len_q[$];
  bit         rnd_ready = 1'b0, ready_fix = 1'b1, use_hdr = 1'b0;
  logic [7:0] hdr [12];
  bit         prev_stall = 1'b0, prev_tv = 1'b0;
  logic [8:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Monitor: pops the scoreboard on every TX handshake.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_tv    = 1'b0;
    end else begin
      if (prev_stall)
        chk("tx_stable", 32'({tx_tvalid, tx_tlast, tx_tdata}), 32'({1'b1, prev_word}));
      if (tx_tvalid && !prev_tv && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (tx_tvalid) chk("tx_tuser", 32'(tx_tuser), 32'd0);
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %0h expected no output", {tx_tlast, tx_tdata});
        end else begin
          chk("tx_byte", 32'({tx_tlast, tx_tdata}), 32'(exp_q.pop_front()));
        end
        out_bytes++;
        if (tx_tlast && len_q.size() > 0) outstanding -= len_q.pop_front();
      end
      if (frame_dropped) drop_cnt++;
      if (fifo_overflow) ovf_cnt++;
      prev_stall = tx_tvalid & ~tx_tready;
      prev_word  = {tx_tlast, tx_tdata};
      prev_tv    = tx_tvalid;
    end
  end

  // Reference: a frame survives iff clean, in length range and it fits; swap exchanges MACs.
  task automatic send_frame(input int len, input bit bad, input bit swap, input bit room);
    logic [7:0] d[$];
    bit ok;
    for (int i = 0; i < len; i++) d.push_back((use_hdr && i < 12) ? hdr[i] : 8'($urandom));
    ok = !bad && len >= MINL && len <= MAXL && room;
    if (ok) begin
      for (int i = 0; i < len; i++) begin
        int src;
        src = i;
        if (swap && i < 6)       src = i + 6;
        else if (swap && i < 12) src = i - 6;
        exp_q.push_back({i == len - 1, d[src]});
      end
      len_q.push_back(len);
      outstanding += len;
    end
    for (int i = 0; i < len; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = d[i];
      rx_tlast  = (i == len - 1);
      rx_tuser  = bad && (i == len - 1);
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
    t_last    = cyc;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 40000 && !(exp_q.size() == 0 && frame_count == 0); k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (k >= 40000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending, frame_count %0d expected 0",
               exp_q.size(), frame_count);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ob0, dr0, ov0, k;
    wait_cycles(3);
    chk("rst_rx_tready", 32'(rx_tready), 32'd0);
    chk("rst_tx", 32'({tx_tvalid, tx_tlast, tx_tuser, tx_tdata}), 32'd0);
    chk("rst_status", 32'({frame_dropped, fifo_overflow, frame_count}), 32'd0);
    reset = 1'b1;
    wait_cycles(1);
    chk("rx_tready_on", 32'(rx_tready), 32'd1);

    // 64-byte frame, no swap, latency and frame_count progression
    ob0 = out_bytes;
    first_tv_cyc = -1;
    chk("cnt_before", 32'(frame_count), 32'd0);
    send_frame(64, 1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    chk("cnt_after_commit", 32'(frame_count), 32'd1);
    wait_drain();
    chk("first_tvalid_latency", 32'(first_tv_cyc - t_last), 32'd3);
    chk("bytes_64", 32'(out_bytes - ob0), 32'd64);

    // 60-byte frame with MAC swap
    hdr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    use_hdr  = 1'b1;
    cfg_swap = 1'b1;
    send_frame(60, 1'b0, 1'b1, 1'b1);
    wait_drain();
    use_hdr  = 1'b0;
    cfg_swap = 1'b0;

    // bad, runt, oversize: all dropped
    ob0 = out_bytes;
    dr0 = drop_cnt;
    send_frame(64, 1'b1, 1'b0, 1'b1);
    send_frame(10, 1'b0, 1'b0, 1'b1);
    send_frame(1600, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    chk("drops_3", 32'(drop_cnt - dr0), 32'd3);
    chk("drops_no_tx", 32'(out_bytes - ob0), 32'd0);
    chk("drops_cnt", 32'(frame_count), 32'd0);
    send_frame(100, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // overflow with TX stalled
    ready_fix = 1'b0;
    wait_cycles(2);
    ob0 = out_bytes;
    dr0 = drop_cnt;
    ov0 = ovf_cnt;
    send_frame(1500, 1'b0, 1'b0, 1'b1);
    send_frame(600, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    chk("ovf_pulses", 32'(ovf_cnt - ov0), 32'd1);
    chk("ovf_drop", 32'(drop_cnt - dr0), 32'd1);
    chk("ovf_cnt", 32'(frame_count), 32'd1);
    ready_fix = 1'b1;
    wait_drain();
    chk("ovf_bytes_out", 32'(out_bytes - ob0), 32'd1500);

    // random back-to-back frames, random tready, swap on
    cfg_swap  = 1'b1;
    rnd_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int len;
      bit bad;
      len = $urandom_range(MINL, MAXL);
      bad = ($urandom_range(0, 7) == 0);
      for (k = 0; k < 20000 && outstanding + len > DEPTH; k++) wait_cycles(1);
      if (k >= 20000) begin
        checks++;
        errors++;
        $display("FAIL space_timeout: got %0d outstanding expected <= %0d", outstanding, DEPTH - len);
      end
      send_frame(len, bad, 1'b1, 1'b1);
    end
    wait_drain();
    rnd_ready = 1'b0;
    ready_fix = 1'b1;
    cfg_swap  = 1'b0;
    chk("rand_cnt", 32'(frame_count), 32'd0);

    // reset in the middle of TX
    ob0 = out_bytes;
    send_frame(200, 1'b0, 1'b0, 1'b1);
    for (k = 0; k < 1000 && out_bytes < ob0 + 50; k++) wait_cycles(1);
    chk("midtx_progress", 32'(out_bytes >= ob0 + 50), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midtx_tvalid", 32'({tx_tvalid, tx_tlast, tx_tdata}), 32'd0);
    chk("midtx_cnt", 32'({rx_tready, frame_count}), 32'd0);
    exp_q.delete();
    len_q.delete();
    outstanding = 0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(1);
    ob0 = out_bytes;
    send_frame(200, 1'b0, 1'b0, 1'b1);
    wait_drain();
    chk("post_reset_bytes", 32'(out_bytes - ob0), 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
